matrix_seq_engine: RTL and testbench
====================================

Name: matrix_seq_engine

Overview:
- Sequential matrix arithmetic engine that sits directly downstream of the HPS control unit.
- The control unit supplies the operation code, the matrix size, and flattened 5x5 operand matrices A and B, plus a start pulse.
- The engine computes one result element per iteration using a single shared multiply-accumulate (MAC) datapath, then returns a flattened 5x5 result with a one-cycle done pulse.

Parameters:
- ELEM_W, 8: element width in bits; elements are signed two's complement.
- MAX_DIM, 5: physical matrix dimension; storage is always MAX_DIM x MAX_DIM, row-major.
- ACC_W, 20: accumulator width; covers 5 products of 8x8 signed without overflow.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- op_code  in  3  operation select
- matrix_size  in  2  00=2x2, 01=3x3, 10=4x4, 11=5x5
- matrix_a  in  200  operand A, element (r,c) at bits [(r*5+c)*8 +: 8]
- matrix_b  in  200  operand B, same layout as A
- result_final  out  200  result matrix, same layout as A
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- process_Done  out  1  one-cycle pulse when result_final is valid
- op_error  out  1  set with process_Done for an invalid op_code; cleared on the next accepted start

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; result_final=0; busy=0; process_Done=0; op_error=0; all counters=0.
- Reset mid-operation aborts immediately; the block comes out of reset in IDLE with all outputs zero.
- Start acceptance (start=1 in IDLE, cycle t0):
  - op_code, matrix_size, A and B are snapshotted into internal registers. Input changes after t0 have no effect.
  - result_final is cleared to 0, so unused positions outside NxN read 0. N = matrix_size+2.
  - start is ignored outside IDLE.
- States:
  - IDLE: wait for start.
  - COMPUTE: iterate row r, column c (c fastest) and, for multiply only, inner index k.
  - DONE: process_Done=1 for exactly one cycle, then return to IDLE.
- Opcodes (per element, N = active dimension):
  - 000 add: A+B.
  - 001 sub: A-B.
  - 010 mul: sum over k of A(r,k)*B(k,c). One MAC per cycle; the accumulator is cleared at k=0.
  - 011 scalar: A(r,c)*B(0,0).
  - 100 transpose: R(c,r)=A(r,c).
  - 101 negate: -A(r,c).
  - 110, 111: invalid. COMPUTE is skipped, DONE is entered at t1, op_error=1, and result_final stays 0.
- Width rules:
  - All intermediates are computed at ACC_W.
  - The stored element saturates to [-128, 127]. Example: negate(-128) stores 127.
- Latency (t0 = start cycle):
  - Elementwise ops: COMPUTE runs t1..t(N*N); process_Done is high at t(N*N+1).
  - Multiply: COMPUTE runs t1..t(N*N*N); process_Done is high at t(N*N*N+1).
  - Examples: 2x2 add gives done at t5; 5x5 multiply gives done at t126.
- Write timing: each element is written on the last cycle of its iteration.
- result_final holds its value after DONE until the next accepted start or reset.
- Boundaries:
  - Counter wrap: c wraps at N-1 and increments r; r wraps at N-1 to finish.
  - start asserted in the DONE cycle is ignored. Start again in IDLE to launch a new operation.

Decomposition:
- Package matrix_pkg holds:
  - opcode constants OP_ADD..OP_NEG,
  - size encodings,
  - MAX_DIM, ELEM_W, ACC_W,
  - a saturate-to-8-bit function,
  - the state enumeration.
- Sub-module matrix_mac is natural: an ELEM_W x ELEM_W signed multiply with an ACC_W accumulator, a clear input, and a saturated output. The engine keeps the FSM, counters and result register file.

Test Plan:
- 2x2 add, A=[1,2;3,4], B=[10,20,30,40] -> done at t5, result [11,22;33,44], all other 21 bytes 0, op_error=0.
- 3x3 multiply, A=identity, B=[1..9] -> done at t28, result equals B. Then A=all 2, B=all 3 -> every element 18.
- 5x5 multiply, A=all 127, B=all 127 -> done at t126, every element saturates to 127. A=all -128, B=all 127 -> every element -128.
- Negate 2x2, A=[-128,5;0,-1] -> [127,-5;0,1]. Transpose 3x3, A=[1..9] -> [1,4,7;2,5,8;3,6,9].
- op_code=111 -> process_Done and op_error high at t1, result all 0. A following valid start clears op_error.
- 5x5 multiply with reset asserted at t40 -> next cycle IDLE, busy=0, result 0, no done pulse. Start pulses issued while busy produce no restart and no extra done pulse.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and element helpers for the matrix sequencing engine.
package matrix_pkg;
   localparam int unsigned ELEM_W  = 8;
   localparam int unsigned MAX_DIM = 5;
   localparam int unsigned ACC_W   = 20;
   localparam int unsigned IDX_W   = 3;
   localparam int unsigned OP_W    = 3;
   localparam int unsigned MAT_W   = ELEM_W * MAX_DIM * MAX_DIM;

   localparam logic [OP_W-1:0] OP_ADD   = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB   = 3'b001;
   localparam logic [OP_W-1:0] OP_MUL   = 3'b010;
   localparam logic [OP_W-1:0] OP_SCALE = 3'b011;
   localparam logic [OP_W-1:0] OP_TRANS = 3'b100;
   localparam logic [OP_W-1:0] OP_NEG   = 3'b101;

   localparam logic [1:0] SIZE_2X2 = 2'b00;
   localparam logic [1:0] SIZE_3X3 = 2'b01;
   localparam logic [1:0] SIZE_4X4 = 2'b10;
   localparam logic [1:0] SIZE_5X5 = 2'b11;

   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
   localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(128);

   typedef enum logic [1:0] {ST_IDLE, ST_COMPUTE, ST_DONE} state_t;

   // Clamp an accumulator-width value into the signed element range.
   function automatic logic signed [ELEM_W-1:0] sat_elem(input logic signed [ACC_W-1:0] v);
      if (v > SAT_HI)      return ELEM_W'(SAT_HI);
      else if (v < SAT_LO) return ELEM_W'(SAT_LO);
      else                 return ELEM_W'(v);
   endfunction

   // Mux-tree read of element (r,c) from a flattened row-major matrix.
   function automatic logic signed [ELEM_W-1:0] get_elem(input logic [MAT_W-1:0] m,
                                                          input logic [IDX_W-1:0] r,
                                                          input logic [IDX_W-1:0] c);
      logic signed [ELEM_W-1:0] e;
      e = '0;
      for (int i = 0; i < int'(MAX_DIM); i++)
         for (int j = 0; j < int'(MAX_DIM); j++)
            if (r == IDX_W'(i) && c == IDX_W'(j))
               e = m[(i*MAX_DIM+j)*ELEM_W +: ELEM_W];
      return e;
   endfunction
endpackage

// File: rtl/matrix_seq_engine_mac.sv
// Shared signed multiply-accumulate: one product per cycle into an ACC_W accumulator.
module matrix_seq_engine_mac
   import matrix_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_en,
   input  logic                     i_clear,
   input  logic signed [ELEM_W-1:0] i_a,
   input  logic signed [ELEM_W-1:0] i_b,
   output logic signed [ACC_W-1:0]  o_sum_c,
   output logic signed [ELEM_W-1:0] o_sat_c
);
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] w_a_ext;
   logic signed [ACC_W-1:0] w_b_ext;
   logic signed [ACC_W-1:0] w_base;

   // Clear drops the stale accumulator so the first term of a new sum starts from zero.
   always_comb begin
      w_a_ext = ACC_W'(i_a);
      w_b_ext = ACC_W'(i_b);
      w_base  = i_clear ? '0 : r_acc;
      o_sum_c = w_base + w_a_ext * w_b_ext;
      o_sat_c = sat_elem(o_sum_c);
   end

   always_ff @(posedge clk) begin
      if (reset)     r_acc <= '0;
      else if (i_en) r_acc <= o_sum_c;
   end
endmodule

// File: rtl/matrix_seq_engine.sv
// Sequential matrix engine: snapshots operands on start, produces one result element per
// iteration through a shared MAC, then pulses process_Done.
module matrix_seq_engine
   import matrix_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [OP_W-1:0]  op_code,
   input  logic [1:0]       matrix_size,
   input  logic [MAT_W-1:0] matrix_a,
   input  logic [MAT_W-1:0] matrix_b,
   output logic [MAT_W-1:0] result_final,
   output logic             busy,
   output logic             process_Done,
   output logic             op_error
);
   state_t           r_state;
   logic [OP_W-1:0]  r_op;
   logic [1:0]       r_size;
   logic [MAT_W-1:0] r_a;
   logic [MAT_W-1:0] r_b;
   logic [IDX_W-1:0] r_row;
   logic [IDX_W-1:0] r_col;
   logic [IDX_W-1:0] r_k;

   logic [IDX_W-1:0]        w_last;
   logic                    w_is_mul;
   logic                    w_use_mac;
   logic                    w_elem_last;
   logic                    w_iter_last;
   logic signed [ELEM_W-1:0] w_a_rc, w_b_rc, w_a_rk, w_b_kc, w_b_00;
   logic signed [ELEM_W-1:0] w_mac_a, w_mac_b, w_mac_sat, w_elem;
   logic                    w_mac_clear, w_mac_en;
   logic signed [ACC_W-1:0] w_mac_sum, w_a_ext, w_b_ext, w_val;
   logic [IDX_W-1:0]        w_dst_r, w_dst_c;

   // Operand selection and elementwise arithmetic at accumulator width.
   always_comb begin
      w_last      = IDX_W'(r_size) + IDX_W'(1);
      w_is_mul    = (r_op == OP_MUL);
      w_use_mac   = w_is_mul || (r_op == OP_SCALE);
      w_a_rc      = get_elem(r_a, r_row, r_col);
      w_b_rc      = get_elem(r_b, r_row, r_col);
      w_a_rk      = get_elem(r_a, r_row, r_k);
      w_b_kc      = get_elem(r_b, r_k, r_col);
      w_b_00      = get_elem(r_b, IDX_W'(0), IDX_W'(0));
      w_mac_a     = w_is_mul ? w_a_rk : w_a_rc;
      w_mac_b     = w_is_mul ? w_b_kc : w_b_00;
      w_mac_clear = !w_is_mul || (r_k == '0);
      w_mac_en    = (r_state == ST_COMPUTE) && w_is_mul;
      w_elem_last = !w_is_mul || (r_k == w_last);
      w_iter_last = w_elem_last && (r_col == w_last) && (r_row == w_last);
      w_a_ext     = ACC_W'(w_a_rc);
      w_b_ext     = ACC_W'(w_b_rc);
      w_val       = '0;
      case (r_op)
         OP_ADD:   w_val = w_a_ext + w_b_ext;
         OP_SUB:   w_val = w_a_ext - w_b_ext;
         OP_TRANS: w_val = w_a_ext;
         OP_NEG:   w_val = -w_a_ext;
         default:  w_val = '0;
      endcase
      w_elem  = w_use_mac ? w_mac_sat : sat_elem(w_val);
      w_dst_r = (r_op == OP_TRANS) ? r_col : r_row;
      w_dst_c = (r_op == OP_TRANS) ? r_row : r_col;
   end

   matrix_seq_engine_mac u_mac (
      .clk     (clk),
      .reset   (reset),
      .i_en    (w_mac_en),
      .i_clear (w_mac_clear),
      .i_a     (w_mac_a),
      .i_b     (w_mac_b),
      .o_sum_c (w_mac_sum),
      .o_sat_c (w_mac_sat)
   );

   // Control FSM, iteration counters and result register file.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_op         <= '0;
         r_size       <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_row        <= '0;
         r_col        <= '0;
         r_k          <= '0;
         result_final <= '0;
         busy         <= 1'b0;
         process_Done <= 1'b0;
         op_error     <= 1'b0;
      end else begin
         process_Done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_op         <= op_code;
                  r_size       <= matrix_size;
                  r_a          <= matrix_a;
                  r_b          <= matrix_b;
                  r_row        <= '0;
                  r_col        <= '0;
                  r_k          <= '0;
                  result_final <= '0;
                  busy         <= 1'b1;
                  if (op_code > OP_NEG) begin
                     op_error     <= 1'b1;
                     process_Done <= 1'b1;
                     r_state      <= ST_DONE;
                  end else begin
                     op_error <= 1'b0;
                     r_state  <= ST_COMPUTE;
                  end
               end
            end
            ST_COMPUTE: begin
               if (w_elem_last) begin
                  for (int i = 0; i < int'(MAX_DIM); i++)
                     for (int j = 0; j < int'(MAX_DIM); j++)
                        if (w_dst_r == IDX_W'(i) && w_dst_c == IDX_W'(j))
                           result_final[(i*MAX_DIM+j)*ELEM_W +: ELEM_W] <= w_elem;
                  r_k <= '0;
                  if (r_col == w_last) begin
                     r_col <= '0;
                     r_row <= r_row + IDX_W'(1);
                  end else begin
                     r_col <= r_col + IDX_W'(1);
                  end
               end else begin
                  r_k <= r_k + IDX_W'(1);
               end
               if (w_iter_last) begin
                  process_Done <= 1'b1;
                  r_state      <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_matrix_seq_engine.sv
// Directed bench for matrix_seq_engine: vector table plus reset-abort and busy-start sequences.
module tb_matrix_seq_engine;
   import matrix_pkg::*;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [2:0]       op_code;
   logic [1:0]       matrix_size;
   logic [MAT_W-1:0] matrix_a;
   logic [MAT_W-1:0] matrix_b;
   logic [MAT_W-1:0] result_final;
   logic             busy;
   logic             process_Done;
   logic             op_error;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string            name;
      logic [2:0]       op;
      logic [1:0]       size;
      logic [MAT_W-1:0] a;
      logic [MAT_W-1:0] b;
      logic [MAT_W-1:0] exp_res;
      int               exp_done;
      logic             exp_err;
   } vec_t;

   vec_t vecs[11];

   matrix_seq_engine dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .op_code      (op_code),
      .matrix_size  (matrix_size),
      .matrix_a     (matrix_a),
      .matrix_b     (matrix_b),
      .result_final (result_final),
      .busy         (busy),
      .process_Done (process_Done),
      .op_error     (op_error)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [MAT_W-1:0] put(input logic [MAT_W-1:0] m, input int r, input int c,
                                            input int v);
      m[(r*5+c)*8 +: 8] = 8'(v);
      return m;
   endfunction

   function automatic logic [MAT_W-1:0] fill(input int v, input int n);
      logic [MAT_W-1:0] m;
      m = '0;
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
            m = put(m, r, c, v);
      return m;
   endfunction

   task automatic run_vec(input vec_t v);
      int cyc;
      logic [MAT_W-1:0] res;
      op_code     = v.op;
      matrix_size = v.size;
      matrix_a    = v.a;
      matrix_b    = v.b;
      start       = 1'b1;
      tick();
      start       = 1'b0;
      op_code     = 3'b000;
      matrix_size = 2'b11;
      matrix_a    = {25{8'h5A}};
      matrix_b    = {25{8'hA5}};
      cyc         = 1;
      chk({v.name, " busy_t1"}, MAT_W'(busy), MAT_W'(1));
      while (!process_Done && cyc < 300) begin
         tick();
         cyc++;
      end
      chk({v.name, " done_cycle"}, MAT_W'(cyc), MAT_W'(v.exp_done));
      chk({v.name, " result"}, result_final, v.exp_res);
      chk({v.name, " op_error"}, MAT_W'(op_error), MAT_W'(v.exp_err));
      res = result_final;
      tick();
      chk({v.name, " post_done_pulse"}, MAT_W'({busy, process_Done}), MAT_W'(0));
      chk({v.name, " result_held"}, result_final, res);
   endtask

   initial begin
      logic [MAT_W-1:0] m, e;
      int cyc, pulses;

      // 2x2 add with a stray element outside the active window
      m = put(put(put(put('0, 0, 0, 1), 0, 1, 2), 1, 0, 3), 1, 1, 4);
      m = put(m, 2, 2, 77);
      e = put(put(put(put('0, 0, 0, 10), 0, 1, 20), 1, 0, 30), 1, 1, 40);
      vecs[0] = '{"add2", OP_ADD, SIZE_2X2, m, e,
                  put(put(put(put('0, 0, 0, 11), 0, 1, 22), 1, 0, 33), 1, 1, 44), 5, 1'b0};
      // 3x3 identity times [1..9]
      m = '0; e = '0;
      for (int i = 0; i < 3; i++) m = put(m, i, i, 1);
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) e = put(e, r, c, r*3+c+1);
      vecs[1] = '{"mul3_id", OP_MUL, SIZE_3X3, m, e, e, 28, 1'b0};
      vecs[2] = '{"mul3_23", OP_MUL, SIZE_3X3, fill(2, 5), fill(3, 5), fill(18, 3), 28, 1'b0};
      vecs[3] = '{"mul5_sat_hi", OP_MUL, SIZE_5X5, fill(127, 5), fill(127, 5), fill(127, 5),
                  126, 1'b0};
      vecs[4] = '{"mul5_sat_lo", OP_MUL, SIZE_5X5, fill(-128, 5), fill(127, 5), fill(-128, 5),
                  126, 1'b0};
      m = put(put(put(put('0, 0, 0, -128), 0, 1, 5), 1, 0, 0), 1, 1, -1);
      vecs[5] = '{"neg2", OP_NEG, SIZE_2X2, m, fill(9, 5),
                  put(put(put(put('0, 0, 0, 127), 0, 1, -5), 1, 0, 0), 1, 1, 1), 5, 1'b0};
      m = '0;
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) m = put(m, r, c, r*3+c+1);
      e = '0;
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) e = put(e, r, c, c*3+r+1);
      vecs[6] = '{"trans3", OP_TRANS, SIZE_3X3, m, '0, e, 10, 1'b0};
      vecs[7] = '{"inv111", 3'b111, SIZE_5X5, fill(7, 5), fill(7, 5), '0, 1, 1'b1};
      // subtract saturating both ways; also clears the previous op_error
      m = put(put(put(put('0, 0, 0, -100), 0, 1, 100), 1, 0, 0), 1, 1, 1);
      e = put(put(put(put('0, 0, 0, 100), 0, 1, -100), 1, 0, 0), 1, 1, 2);
      vecs[8] = '{"sub2_sat", OP_SUB, SIZE_2X2, m, e,
                  put(put(put(put('0, 0, 0, -128), 0, 1, 127), 1, 0, 0), 1, 1, -1), 5, 1'b0};
      // scalar 4x4: A(r,c)=r+c, B(0,0)=3
      m = '0; e = '0;
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
         m = put(m, r, c, r + c);
         e = put(e, r, c, 3 * (r + c));
      end
      m = put(m, 4, 4, 99);
      vecs[9] = '{"scale4", OP_SCALE, SIZE_4X4, m, put(fill(50, 5), 0, 0, 3), e, 17, 1'b0};
      vecs[10] = '{"inv110", 3'b110, SIZE_2X2, fill(1, 5), fill(1, 5), '0, 1, 1'b1};

      reset = 1'b1; start = 1'b0; op_code = '0; matrix_size = '0;
      matrix_a = '0; matrix_b = '0;
      repeat (3) tick();
      reset = 1'b0;
      chk("reset_outputs", MAT_W'({busy, process_Done, op_error}), MAT_W'(0));
      chk("reset_result", result_final, '0);

      for (int i = 0; i < 11; i++) run_vec(vecs[i]);

      // Reset during a 5x5 multiply aborts immediately
      op_code = OP_MUL; matrix_size = SIZE_5X5;
      matrix_a = fill(1, 5); matrix_b = fill(1, 5);
      start = 1'b1;
      tick();
      start = 1'b0;
      pulses = 0;
      for (cyc = 1; cyc < 40; cyc++) begin
         if (process_Done) pulses++;
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_outputs", MAT_W'({busy, process_Done, op_error}), MAT_W'(0));
      chk("abort_result", result_final, '0);
      for (int i = 0; i < 130; i++) begin
         if (process_Done || busy) pulses++;
         tick();
      end
      chk("abort_no_done", MAT_W'(pulses), MAT_W'(0));

      // Start pulses while busy and in the DONE cycle are ignored
      op_code = OP_MUL; matrix_size = SIZE_5X5;
      matrix_a = fill(1, 5); matrix_b = fill(1, 5);
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      pulses = 0;
      while (!process_Done && cyc < 300) begin
         if (cyc == 3 || cyc == 60) begin
            op_code = OP_ADD; matrix_size = SIZE_2X2; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         cyc++;
      end
      chk("busy_start_done_cycle", MAT_W'(cyc), MAT_W'(126));
      chk("busy_start_result", result_final, fill(5, 5));
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (process_Done || busy) pulses++;
         tick();
      end
      chk("done_cycle_start_ignored", MAT_W'(pulses), MAT_W'(0));
      chk("result_held_idle", result_final, fill(5, 5));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
